// File: rtl/dcache_axi_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dcache_axi_master                                            |
// | Description : Dcache-side AXI master. Turns cache line refills into 8-beat |
// |               INCR read bursts and dirty-line writebacks into 8-beat INCR  |
// |               write bursts through a one-line write buffer. A same-line    |
// |               hazard check holds a refill back until a buffered writeback  |
// |               to that line has completed.                                  |
// |               Optional feature macro: DCACHE_UNCACHED_EN (single-word      |
// |               uncached reads/writes).                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

`ifndef DCACHE_RID
`define DCACHE_RID 4'd0
`endif

module dcache_axi_master #(
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] AXI_ID     = `DCACHE_RID
) (
    input  logic                      clk,
    input  logic                      rst,
    // cache read side
    input  logic                      rd_req,
    input  logic [31:0]               rd_addr,
    input  logic                      rd_uncached,
    output logic                      rd_rdy,
    output logic                      ret_valid,
    output logic [31:0]               ret_data,
    output logic                      ret_last,
    // cache write side
    input  logic                      wr_req,
    input  logic [31:0]               wr_addr,
    input  logic [LINE_WORDS*32-1:0]  wr_data,
    input  logic                      wr_uncached,
    input  logic [3:0]                wr_strb,
    output logic                      wr_rdy,
    output logic                      wr_done,
    // AXI read address channel
    output logic [3:0]                arid,
    output logic [31:0]               araddr,
    output logic [3:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic [1:0]                arlock,
    output logic [3:0]                arcache,
    output logic [2:0]                arprot,
    output logic                      arvalid,
    input  logic                      arready,
    // AXI read data channel
    input  logic [3:0]                rid,
    input  logic [31:0]               rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready,
    // AXI write address channel
    output logic [3:0]                awid,
    output logic [31:0]               awaddr,
    output logic [3:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic [1:0]                awlock,
    output logic [3:0]                awcache,
    output logic [2:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,
    // AXI write data channel
    output logic [3:0]                wid,
    output logic [31:0]               wdata,
    output logic [3:0]                wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    // AXI write response channel
    input  logic [3:0]                bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready
);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_AR   = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_AW   = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_B    = 2'd3;

    localparam logic [3:0] c_BURST_LEN = 4'(LINE_WORDS - 1);
    localparam logic [2:0] c_LAST_BEAT = 3'(LINE_WORDS - 1);

    logic [1:0]              r_rd_state;
    logic [1:0]              w_rd_state_nxt;
    logic [26:0]             r_rd_line;

    logic [1:0]              r_wr_state;
    logic [1:0]              w_wr_state_nxt;
    logic [26:0]             r_wbuf_line;
    logic [LINE_WORDS*32-1:0] r_wbuf;
    logic                    r_wbuf_valid;
    logic [2:0]              r_cnt;

    logic                    w_wr_accept;
    logic                    w_rd_accept;
    logic                    w_hazard;
    logic                    w_wlast;
    logic                    w_unused;

    // A refill must not overtake a writeback to the same line, whether that
    // writeback is already buffered or is being captured this very cycle.
    assign w_wr_accept = wr_req & (r_wr_state == W_IDLE);
    assign w_hazard    = (r_wbuf_valid & (rd_addr[31:5] == r_wbuf_line)) |
                         (w_wr_accept  & (rd_addr[31:5] == wr_addr[31:5]));
    assign rd_rdy      = (r_rd_state == R_IDLE) & ~w_hazard;
    assign w_rd_accept = rd_req & rd_rdy;
    assign wr_rdy      = (r_wr_state == W_IDLE);

    // Read FSM next-state decode.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_rd_accept)      w_rd_state_nxt = R_AR;
            R_AR:    if (arready)          w_rd_state_nxt = R_DATA;
            R_DATA:  if (rvalid & rlast)   w_rd_state_nxt = R_IDLE;
            default:                       w_rd_state_nxt = R_IDLE;
        endcase
    end

    // Read FSM state and latched refill line address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_rd_line  <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            if (w_rd_accept) r_rd_line <= rd_addr[31:5];
        end
    end

    assign arvalid   = (r_rd_state == R_AR);
    assign rready    = (r_rd_state == R_DATA);
    assign ret_valid = rvalid & rready;
    assign ret_data  = rdata;
    assign ret_last  = rlast;

    assign arid    = AXI_ID;
    assign arsize  = 3'd2;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    // Write FSM next-state decode.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (w_wr_accept)      w_wr_state_nxt = W_AW;
            W_AW:    if (awready)          w_wr_state_nxt = W_DATA;
            W_DATA:  if (wready & w_wlast) w_wr_state_nxt = W_B;
            W_B:     if (bvalid)           w_wr_state_nxt = W_IDLE;
            default:                       w_wr_state_nxt = W_IDLE;
        endcase
    end

    // Write FSM state, line buffer capture and beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state   <= W_IDLE;
            r_wbuf_line  <= '0;
            r_wbuf       <= '0;
            r_wbuf_valid <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            if (w_wr_accept) begin
                r_wbuf_line  <= wr_addr[31:5];
                r_wbuf       <= wr_data;
                r_wbuf_valid <= 1'b1;
                r_cnt        <= '0;
            end else begin
                if (wvalid & wready)               r_cnt        <= r_cnt + 3'd1;
                if ((r_wr_state == W_B) & bvalid)  r_wbuf_valid <= 1'b0;
            end
        end
    end

    assign awvalid = (r_wr_state == W_AW);
    assign wvalid  = (r_wr_state == W_DATA);
    assign bready  = (r_wr_state == W_B);
    assign wr_done = (r_wr_state == W_B) & bvalid;
    assign wdata   = r_wbuf[{r_cnt, 5'b0} +: 32];
    assign wlast   = w_wlast;

    assign awid    = AXI_ID;
    assign wid     = AXI_ID;
    assign awsize  = 3'd2;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

`ifdef DCACHE_UNCACHED_EN
    logic       r_rd_unc;
    logic [4:0] r_rd_lo;
    logic       r_wr_unc;
    logic [4:0] r_wr_lo;
    logic [3:0] r_wr_strb;

    // Capture the single-word qualifiers alongside each accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_unc  <= 1'b0;
            r_rd_lo   <= '0;
            r_wr_unc  <= 1'b0;
            r_wr_lo   <= '0;
            r_wr_strb <= '0;
        end else begin
            if (w_rd_accept) begin
                r_rd_unc <= rd_uncached;
                r_rd_lo  <= rd_addr[4:0];
            end
            if (w_wr_accept) begin
                r_wr_unc  <= wr_uncached;
                r_wr_lo   <= wr_addr[4:0];
                r_wr_strb <= wr_strb;
            end
        end
    end

    assign araddr  = r_rd_unc ? {r_rd_line, r_rd_lo} : {r_rd_line, 5'b0};
    assign arlen   = r_rd_unc ? 4'd0 : c_BURST_LEN;
    assign awaddr  = r_wr_unc ? {r_wbuf_line, r_wr_lo} : {r_wbuf_line, 5'b0};
    assign awlen   = r_wr_unc ? 4'd0 : c_BURST_LEN;
    assign wstrb   = r_wr_unc ? r_wr_strb : 4'hF;
    assign w_wlast = r_wr_unc | (r_cnt == c_LAST_BEAT);
    assign w_unused = &{1'b0, rid, rresp, bid, bresp};
`else
    assign araddr  = {r_rd_line, 5'b0};
    assign arlen   = c_BURST_LEN;
    assign awaddr  = {r_wbuf_line, 5'b0};
    assign awlen   = c_BURST_LEN;
    assign wstrb   = 4'hF;
    assign w_wlast = (r_cnt == c_LAST_BEAT);
    // Responses and single-word qualifiers carry no meaning in this build.
    assign w_unused = &{1'b0, rd_addr[4:0], wr_addr[4:0], rd_uncached,
                        wr_uncached, wr_strb, rid, rresp, bid, bresp};
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_axi_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dcache_axi_master                                         |
// | Description : Scoreboard bench for dcache_axi_master with a small AXI      |
// |               slave model; expected transfers are queued by the stimulus  |
// |               and consumed by a monitor on the falling edge.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dcache_axi_master;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd_req = 1'b0, rd_uncached = 1'b0, wr_req = 1'b0, wr_uncached = 1'b0;
    logic [31:0]  rd_addr = '0, wr_addr = '0;
    logic [255:0] wr_data = '0;
    logic [3:0]   wr_strb = '0;
    logic         rd_rdy, ret_valid, ret_last, wr_rdy, wr_done;
    logic [31:0]  ret_data;
    logic [3:0]   arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
    logic [31:0]  araddr, awaddr, wdata;
    logic [2:0]   arsize, arprot, awsize, awprot;
    logic [1:0]   arburst, arlock, awburst, awlock;
    logic         arvalid, rready, awvalid, wvalid, wlast, bready;
    logic         arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
    logic         awready = 1'b1, wready = 1'b0, bvalid = 1'b0;
    logic [31:0]  rdata = '0;

    dcache_axi_master #(.LINE_WORDS(8), .AXI_ID(4'd5)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_uncached(rd_uncached), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_data(ret_data), .ret_last(ret_last),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_uncached(wr_uncached),
        .wr_strb(wr_strb), .wr_rdy(wr_rdy), .wr_done(wr_done),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(4'd5), .rdata(rdata), .rresp(2'b00), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(4'd5), .bresp(2'b00), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard queues and slave-model bookkeeping
    logic [35:0] exp_ar_q[$];
    logic [32:0] exp_ret_q[$];
    logic [35:0] exp_aw_q[$];
    logic [36:0] exp_w_q[$];
    int          exp_done = 0;
    logic [31:0] r_pend_q[$];
    int          b_pend = 0;
    int          ar_hs = 0, w_hs = 0;
    int          done_cyc = -100, ar_rise_cyc = -100;
    int          ar_hold = 0;
    int          w_mode = 1;
    logic        prev_arvalid = 1'b0, ar_wait = 1'b0;
    logic [31:0] ar_hold_addr = '0;
    logic [35:0] e36;
    logic [32:0] e33;
    logic [36:0] e37;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s actual=unexpected_handshake required=none", nm);
    endtask

    // monitor: compare every handshake against the queued expectation
    always @(negedge clk) begin
        if (rst) begin
            prev_arvalid = 1'b0;
            ar_wait      = 1'b0;
        end else begin
            if (ar_wait) begin
                chk("ar_hold_valid", arvalid, 1'b1);
                chk("ar_hold_addr", araddr, ar_hold_addr);
            end
            if (arvalid && !prev_arvalid) ar_rise_cyc = cyc;
            prev_arvalid = arvalid;
            ar_wait      = arvalid && !arready;
            ar_hold_addr = araddr;
            if (arvalid && arready) begin
                ar_hs++;
                if (exp_ar_q.size() == 0) unexpected("ar_beat");
                else begin
                    e36 = exp_ar_q.pop_front();
                    chk("ar_addr_len", {araddr, arlen}, e36);
                    chk("ar_fields", {arsize, arburst, arlock, arcache, arprot, arid},
                        {3'd2, 2'b01, 2'd0, 4'd0, 3'd0, 4'd5});
                    r_pend_q.push_back(araddr);
                end
            end
            if (ret_valid) begin
                if (exp_ret_q.size() == 0) unexpected("ret_beat");
                else begin
                    e33 = exp_ret_q.pop_front();
                    chk("ret_beat", {ret_data, ret_last}, e33);
                end
            end
            if (awvalid && awready) begin
                if (exp_aw_q.size() == 0) unexpected("aw_beat");
                else begin
                    e36 = exp_aw_q.pop_front();
                    chk("aw_addr_len", {awaddr, awlen}, e36);
                    chk("aw_fields", {awsize, awburst, awlock, awcache, awprot, awid},
                        {3'd2, 2'b01, 2'd0, 4'd0, 3'd0, 4'd5});
                end
            end
            if (wvalid && wready) begin
                w_hs++;
                if (exp_w_q.size() == 0) unexpected("w_beat");
                else begin
                    e37 = exp_w_q.pop_front();
                    chk("w_beat", {wdata, wlast, wstrb}, e37);
                    chk("w_id", wid, 4'd5);
                end
                if (wlast) b_pend++;
            end
            if (wr_done) begin
                done_cyc = cyc;
                if (exp_done == 0) unexpected("wr_done");
                else exp_done--;
            end
        end
    end

    // slave: arready low while a requested stall count runs down
    always @(posedge clk) begin
        #1;
        if (ar_hold > 0 && arvalid) ar_hold--;
        arready = (ar_hold == 0);
    end

    // slave: wready pattern 0=low, 1=high, 2=toggle
    always @(posedge clk) begin
        #1;
        case (w_mode)
            0:       wready = 1'b0;
            1:       wready = 1'b1;
            default: wready = ~wready;
        endcase
    end

    // slave: 8 read beats, data = araddr + beat index
    initial begin
        logic [31:0] a;
        forever begin
            @(posedge clk); #1;
            if (r_pend_q.size() > 0) begin
                a = r_pend_q.pop_front();
                for (int i = 0; i < 8; i++) begin
                    rvalid = 1'b1;
                    rdata  = a + 32'(i);
                    rlast  = (i == 7);
                    @(posedge clk); #1;
                end
                rvalid = 1'b0;
                rlast  = 1'b0;
            end
        end
    end

    // slave: one B response a couple of cycles after the last W beat
    initial begin
        forever begin
            @(posedge clk); #1;
            if (b_pend > 0) begin
                b_pend--;
                @(posedge clk); #1;
                bvalid = 1'b1;
                @(posedge clk); #1;
                bvalid = 1'b0;
            end
        end
    end

    function automatic logic [255:0] mkline(input logic [31:0] base, input logic [31:0] step);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i) * step;
        return l;
    endfunction

    task automatic exp_read(input logic [31:0] line_addr);
        exp_ar_q.push_back({line_addr, 4'd7});
        for (int i = 0; i < 8; i++) exp_ret_q.push_back({line_addr + 32'(i), i == 7});
    endtask

    task automatic exp_write(input logic [31:0] line_addr, input logic [31:0] base,
                             input logic [31:0] step);
        exp_aw_q.push_back({line_addr, 4'd7});
        for (int i = 0; i < 8; i++) exp_w_q.push_back({base + 32'(i) * step, i == 7, 4'hF});
        exp_done++;
    endtask

    task automatic issue_read(input logic [31:0] a, output int acc);
        int k;
        @(posedge clk); #1;
        rd_req = 1'b1; rd_addr = a;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rd_rdy) break;
        end
        acc = cyc;
        chk("rd_accept_in_time", k < 200, 1'b1);
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic issue_write(input logic [31:0] a, input logic [255:0] d);
        int k;
        @(posedge clk); #1;
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (wr_rdy) break;
        end
        chk("wr_accept_in_time", k < 200, 1'b1);
        @(posedge clk); #1;
        wr_req = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (exp_ar_q.size() == 0 && exp_ret_q.size() == 0 && exp_aw_q.size() == 0 &&
                exp_w_q.size() == 0 && exp_done == 0 && rd_rdy && wr_rdy) break;
        end
        chk(nm, k < 400, 1'b1);
    endtask

    initial begin
        int acc, hs0, w0, k;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_rdy", rd_rdy, 1'b1);
        chk("rst_wr_rdy", wr_rdy, 1'b1);
        chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready, wr_done, ret_valid}, 7'd0);

        // refill of an unaligned address
        exp_read(32'h1000_0020);
        issue_read(32'h1000_0024, acc);
        wait_idle("t1_idle");
        chk("t1_ar_latency", ar_rise_cyc, acc + 1);

        // writeback with wready toggling
        w_mode = 2;
        exp_write(32'h2000_0040, 32'd0, 32'd1);
        issue_write(32'h2000_0040, mkline(32'd0, 32'd1));
        wait_idle("t2_idle");
        w_mode = 1;

        // same-line write and read in the same cycle
        exp_write(32'h3000_0000, 32'h3300_0000, 32'd1);
        exp_read(32'h3000_0000);
        @(posedge clk); #1;
        wr_req = 1'b1; wr_addr = 32'h3000_0000; wr_data = mkline(32'h3300_0000, 32'd1);
        rd_req = 1'b1; rd_addr = 32'h3000_0008;
        @(negedge clk);
        chk("t3_wr_rdy", wr_rdy, 1'b1);
        chk("t3_rd_stall", rd_rdy, 1'b0);
        @(posedge clk); #1;
        wr_req = 1'b0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rd_rdy) break;
        end
        chk("t3_rd_accept_in_time", k < 200, 1'b1);
        @(posedge clk); #1;
        rd_req = 1'b0;
        wait_idle("t3_idle");
        chk("t3_ar_after_done", ar_rise_cyc, done_cyc + 2);

        // unrelated read while a writeback is stalled in W_DATA
        w_mode = 0;
        exp_write(32'h4000_0000, 32'hA000_0000, 32'h111);
        issue_write(32'h4000_0000, mkline(32'hA000_0000, 32'h111));
        exp_read(32'h5000_0000);
        issue_read(32'h5000_0000, acc);
        @(negedge clk);
        chk("t4_arvalid_n1", arvalid, 1'b1);
        chk("t4_write_inflight", awvalid | wvalid, 1'b1);
        for (k = 0; k < 100 && exp_ret_q.size() != 0; k++) @(negedge clk);
        w_mode = 1;
        wait_idle("t4_idle");
        chk("t4_ar_latency", ar_rise_cyc, acc + 1);

        // arready held low: stable AR, single handshake
        @(negedge clk);
        ar_hold = 5;
        hs0 = ar_hs;
        exp_read(32'h6000_0000);
        issue_read(32'h6000_001C, acc);
        wait_idle("t5_idle");
        chk("t5_ar_handshakes", ar_hs - hs0, 1);

        // reset while in W_DATA after three beats
        w0 = w_hs;
        exp_write(32'h7000_0000, 32'h7700_0000, 32'd4);
        issue_write(32'h7000_0000, mkline(32'h7700_0000, 32'd4));
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (w_hs - w0 >= 3) break;
        end
        w_mode = 0;
        @(posedge clk); #2;
        chk("t6_in_wdata", wvalid, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_valids_drop", {arvalid, awvalid, wvalid, rready, bready, wr_done, ret_valid}, 7'd0);
        exp_w_q.delete();
        exp_aw_q.delete();
        exp_done = 0;
        b_pend   = 0;
        w_mode   = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_rd_rdy", rd_rdy, 1'b1);
        chk("t6_wr_rdy", wr_rdy, 1'b1);
        exp_read(32'h7000_0000);
        issue_read(32'h7000_0000, acc);
        wait_idle("t6_idle");
        chk("t6_ar_latency", ar_rise_cyc, acc + 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/dcache_axi_master.md
# dcache_axi_master

Dcache-side AXI master that converts cache line refill and dirty-line writeback requests into AXI bursts on channel 1 of the 2-to-1 AXI arbiter. Reads go out as 8-beat INCR bursts and return word by word to the cache. Writebacks are captured into a one-line write buffer, so the cache is released before the write completes. A same-line read-after-write hazard check keeps a refill from overtaking a pending writeback.

## Interface
- Parameters:
- `LINE_WORDS`, 8: words per cache line; fixed at 8, so 256-bit line, 3-bit beat counter, `arlen`/`awlen` = 7.
- `AXI_ID`, `` `DCACHE_RID ``: value driven on `arid`/`awid`/`wid`. The arbiter ORs in bit 1.
- Ports:
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rd_req` in 1: refill request.
- `rd_addr` in 32: refill address.
- `rd_uncached` in 1: single-word read (only used with the macro).
- `rd_rdy` out 1: read request accepted this cycle when it is high together with `rd_req`.
- `ret_valid` out 1, `ret_data` out 32, `ret_last` out 1: returned read beats.
- `wr_req` in 1, `wr_addr` in 32, `wr_data` in 256: writeback request. Word 0 is `wr_data[31:0]`.
- `wr_uncached` in 1, `wr_strb` in 4: single-word write (only used with the macro).
- `wr_rdy` out 1: write request accepted.
- `wr_done` out 1: one-cycle pulse on the B handshake.
- AXI master ports `ar*`, `r*`, `aw*`, `w*`, `b*`: same widths as the arbiter's channel-1 slave ports.

## Operation
- Read FSM: `R_IDLE` → `R_AR` → `R_DATA` → `R_IDLE`.
  - `rd_rdy` = `R_IDLE` and no hazard.
  - On accept, latch the address and go to `R_AR`.
  - In `R_AR`, `arvalid`=1 and is held until `arready`; then go to `R_DATA`.
  - In `R_DATA`, `rready`=1.
  - `ret_valid` = `rvalid & rready`; `ret_data` = `rdata`; `ret_last` = `rlast`.
  - Return to `R_IDLE` on the beat where `rlast` and `rvalid` are both high.
- AR fields:
  - `araddr` = {addr[31:5], 5'b0}.
  - `arlen` = 7, `arsize` = 2, `arburst` = 2'b01.
  - `arlock`, `arcache`, `arprot` = 0.
  - `arid` = `AXI_ID`.
- Write FSM: `W_IDLE` → `W_AW` → `W_DATA` → `W_B` → `W_IDLE`.
  - `wr_rdy` = `W_IDLE`.
  - On accept, capture `wr_addr`/`wr_data` into the buffer and set `wbuf_valid`.
  - In `W_AW`, `awvalid` is held until `awready`.
  - In `W_DATA`, `wvalid`=1 and `wdata` = buffer word[cnt]. `cnt` increments on each `wvalid & wready`. `wlast` = (cnt==7). Go to `W_B` after the last beat.
  - In `W_B`, `bready`=1. On `bvalid`, pulse `wr_done`, clear `wbuf_valid`, and go to `W_IDLE`.
- AW/W fields:
  - `awaddr` = {addr[31:5], 5'b0}.
  - `awlen` = 7, `awsize` = 2, `awburst` = 2'b01.
  - `wstrb` = 4'hF.
  - `awid` = `wid` = `AXI_ID`.
- Hazard: a read is stalled (`rd_rdy`=0) when `rd_addr[31:5]` matches the line address of a pending buffered write (`wbuf_valid`), or matches `wr_addr[31:5]` while a write is being accepted in the same cycle.
- The read and write FSMs are independent; an unrelated read proceeds while a writeback is in flight.
- `bresp`/`rresp` are ignored.

## Timing
- Reset values:
  - All FSMs in IDLE; `cnt`=0; `wbuf_valid`=0.
  - `arvalid`, `awvalid`, `wvalid`, `rready`, `bready`, `wr_done`, `ret_valid` = 0.
  - `rd_rdy`=1 and `wr_rdy`=1 (combinational, because both FSMs are in IDLE).
- Latency:
  - Request accepted at cycle N → `arvalid`/`awvalid` high at N+1.
  - First `wvalid` is in the cycle after the AW handshake.
  - Returned data has zero added latency (combinational pass-through).
- Handshakes: once asserted, the valids and all payloads stay stable until ready.
- Simultaneous `rd_req` and `wr_req` on the same line: the write is accepted and the read waits until `wr_done`. The read is accepted in the cycle after `wr_done`.
- Reset mid-transaction: asynchronous return to IDLE, all valids drop immediately, and the in-flight AXI transaction is abandoned. Reset is system-wide.
- `rlast` arriving early ends the read. Extra beats after `rlast` are not expected.

## Configuration
- `DCACHE_UNCACHED_EN` defined:
  - `rd_uncached` produces `araddr` = `rd_addr` unaligned, `arlen`=0; the single beat has `ret_last`=1.
  - `wr_uncached` produces `awaddr` = `wr_addr`, `awlen`=0, one beat of word 0 with `wstrb` = `wr_strb` and `wlast`=1.
  - The hazard compare still uses `[31:5]`.
- Not defined: `rd_uncached`, `wr_uncached` and `wr_strb` are ignored; every access is a full-line burst.

## Test plan
- Read of `rd_addr`=0x1000_0024 with `arready`=1 → `araddr`=0x1000_0020, `arlen`=7; 8 `ret_valid` beats; `ret_last` only on beat 8; back to `rd_rdy`=1.
- Writeback to 0x2000_0040 with words 0..7 = 0..7 and `wready` toggling every cycle → `awlen`=7; `wdata` sequence 0..7 with no gaps or duplicates; `wlast` on beat 8; one `wr_done` pulse after `bvalid`.
- Same-cycle `wr_req` and `rd_req` to line 0x3000_0000 → `wr_rdy`=1, `rd_rdy`=0; `arvalid` stays low until the cycle after `wr_done`.
- Writeback to 0x4000_0000 in flight, read of 0x5000_0000 → `arvalid` rises at N+1, independently of the write.
- `arready` held low for 5 cycles → `arvalid` and `araddr` stable throughout; exactly one AR handshake.
- Reset asserted in `W_DATA` at beat 3 → all valids 0 in the same cycle; `rd_rdy`=`wr_rdy`=1 after release.
